// File: rtl/writeback_pkg.sv
// Shared types and elaboration helpers for the result writeback buffer.
// Contents:
//   wb_state_e   - controller states
//   p_divides_n  - true when the beat width evenly tiles a row
//   idx_width    - counter width able to index 0..n-1 (at least 1 bit)
package writeback_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWaitTurn,
    StWrite,
    StSignalDone
  } wb_state_e;

  function automatic bit p_divides_n(input int unsigned n, input int unsigned p);
    return (p != 0) && (p <= n) && ((n % p) == 0);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_tile_store.sv
// N x N register array holding one result tile.
// Ports:
//   clk             - clock
//   i_wr_en         - write one full row
//   i_wr_row        - row index for the write
//   i_wr_data       - row contents, index j = column j
//   i_rd_row        - row index for the read
//   i_rd_col_base   - first column of the P-wide read window
//   o_rd_data       - o_rd_data[k] = tile[i_rd_row][i_rd_col_base + k]
module result_tile_store
  import writeback_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned P         = 4,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned IDX_W     = idx_width(N)
) (
  input  logic                          clk,
  input  logic                          i_wr_en,
  input  logic [IDX_W-1:0]              i_wr_row,
  input  logic [N-1:0][ACC_WIDTH-1:0]   i_wr_data,
  input  logic [IDX_W-1:0]              i_rd_row,
  input  logic [IDX_W-1:0]              i_rd_col_base,
  output logic [P-1:0][ACC_WIDTH-1:0]   o_rd_data
);

  // Contents are never reset; a tile is always fully written before it is read.
  logic [N-1:0][ACC_WIDTH-1:0] r_tile [N];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tile[i_wr_row] <= i_wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(P); k++) begin
      o_rd_data[k] = r_tile[i_rd_row][i_rd_col_base + IDX_W'(k)];
    end
  end

endmodule

// File: rtl/result_writeback_buffer.sv
// Collects one N x N result tile from the processor, waits for its turn on
// the shared memory port (done-token chain), then streams the tile to memory
// P elements per beat, row by row with a programmable row stride.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   i_instruction_valid/o_..._ready  - tile instruction handshake
//   i_address_input, i_stride_input - element address of tile[0][0], row stride
//   i_processor_output_*             - result rows (valid/ready/data/last)
//   i_previous_done_writing_valid,
//   o_previous_done_writing_ready    - token from the previous unit
//   o_current_done_writing_valid,
//   i_current_done_writing_ready     - token to the next unit
//   o_memory_write_enable/i_..._ready,
//   o_memory_address, o_memory_write_data - memory write beats
//   o_protocol_error                 - pulse when last is misplaced
module result_writeback_buffer
  import writeback_pkg::*;
#(
  parameter int unsigned ACC_WIDTH                    = 32,
  parameter int unsigned N                            = 4,
  parameter int unsigned MEMORY_ADDRESS_BITS          = 64,
  parameter int unsigned PARALLEL_DATA_STREAMING_SIZE = 4,
  parameter int unsigned MAX_MATRIX_LENGTH            = 4096,
  parameter int unsigned STRIDE_BITS                  = $clog2(MAX_MATRIX_LENGTH + 1)
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              i_instruction_valid,
  output logic                                              o_instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                    i_address_input,
  input  logic [STRIDE_BITS-1:0]                            i_stride_input,
  input  logic                                              i_processor_output_valid,
  output logic                                              o_processor_output_ready,
  input  logic [N-1:0][ACC_WIDTH-1:0]                       i_processor_output_data,
  input  logic                                              i_processor_output_last,
  input  logic                                              i_previous_done_writing_valid,
  output logic                                              o_previous_done_writing_ready,
  output logic                                              o_current_done_writing_valid,
  input  logic                                              i_current_done_writing_ready,
  output logic                                              o_memory_write_enable,
  input  logic                                              i_memory_write_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]                    o_memory_address,
  output logic [PARALLEL_DATA_STREAMING_SIZE-1:0][ACC_WIDTH-1:0] o_memory_write_data,
  output logic                                              o_protocol_error
);

  localparam int unsigned P    = PARALLEL_DATA_STREAMING_SIZE;
  localparam int unsigned IdxW = idx_width(N);

  if (!p_divides_n(N, P)) begin : g_bad_p
    $error("PARALLEL_DATA_STREAMING_SIZE must divide N");
  end

  wb_state_e                    r_state, w_state_next;
  logic [IdxW-1:0]              r_row_cnt, r_col_cnt;
  logic                         r_token;
  logic [MEMORY_ADDRESS_BITS-1:0] r_addr;
  logic [STRIDE_BITS-1:0]       r_stride;
  logic                         r_perr;

  logic                         w_row_acc, w_tok_acc, w_beat_acc;
  logic                         w_last_row, w_last_col;
  logic [MEMORY_ADDRESS_BITS-1:0] w_addr;
  logic [P-1:0][ACC_WIDTH-1:0]  w_rd_data;

  assign w_last_row = (r_row_cnt == IdxW'(N - 1));
  assign w_last_col = (r_col_cnt == IdxW'(N - P));
  assign w_row_acc  = (r_state == StCollect) && i_processor_output_valid;
  assign w_beat_acc = (r_state == StWrite) && i_memory_write_ready;

  // The flag only accepts while a tile is in flight, so an idle unit never
  // swallows a token meant for its next instruction.
  assign o_previous_done_writing_ready = ~r_token && (r_state != StIdle);
  assign w_tok_acc = i_previous_done_writing_valid && o_previous_done_writing_ready;

  assign w_addr = r_addr
                + (MEMORY_ADDRESS_BITS'(r_row_cnt) * MEMORY_ADDRESS_BITS'(r_stride))
                + MEMORY_ADDRESS_BITS'(r_col_cnt);

  always_comb begin
    w_state_next                 = r_state;
    o_instruction_ready          = 1'b0;
    o_processor_output_ready     = 1'b0;
    o_memory_write_enable        = 1'b0;
    o_current_done_writing_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_instruction_ready = 1'b1;
        if (i_instruction_valid) w_state_next = StCollect;
      end
      StCollect: begin
        o_processor_output_ready = 1'b1;
        if (w_row_acc && w_last_row) w_state_next = StWaitTurn;
      end
      StWaitTurn: begin
        if (r_token) w_state_next = StWrite;
      end
      StWrite: begin
        o_memory_write_enable = 1'b1;
        if (w_beat_acc && w_last_row && w_last_col) w_state_next = StSignalDone;
      end
      StSignalDone: begin
        o_current_done_writing_valid = 1'b1;
        if (i_current_done_writing_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Gate address/data so they read zero outside the write phase.
  assign o_memory_address    = o_memory_write_enable ? w_addr : '0;
  assign o_memory_write_data = o_memory_write_enable ? w_rd_data : '0;
  assign o_protocol_error    = r_perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
      r_token   <= 1'b0;
      r_addr    <= '0;
      r_stride  <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // last is only checked; the row count alone decides the tile end.
      r_perr  <= w_row_acc && (i_processor_output_last != w_last_row);
      if (w_tok_acc) begin
        r_token <= 1'b1;
      end else if (r_state == StWaitTurn) begin
        r_token <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (i_instruction_valid) begin
            r_addr    <= i_address_input;
            r_stride  <= i_stride_input;
            r_row_cnt <= '0;
          end
        end
        StCollect: begin
          if (w_row_acc) r_row_cnt <= r_row_cnt + IdxW'(1);
        end
        StWaitTurn: begin
          if (r_token) begin
            r_row_cnt <= '0;
            r_col_cnt <= '0;
          end
        end
        StWrite: begin
          if (w_beat_acc) begin
            if (w_last_col) begin
              r_col_cnt <= '0;
              r_row_cnt <= r_row_cnt + IdxW'(1);
            end else begin
              r_col_cnt <= r_col_cnt + IdxW'(P);
            end
          end
        end
        default: ;
      endcase
    end
  end

  result_tile_store #(
    .N         (N),
    .P         (P),
    .ACC_WIDTH (ACC_WIDTH),
    .IDX_W     (IdxW)
  ) u_store (
    .clk           (clk),
    .i_wr_en       (w_row_acc),
    .i_wr_row      (r_row_cnt),
    .i_wr_data     (i_processor_output_data),
    .i_rd_row      (r_row_cnt),
    .i_rd_col_base (r_col_cnt),
    .o_rd_data     (w_rd_data)
  );

endmodule

// File: tb/tb_result_writeback_buffer.sv
// Directed-plus-random bench for result_writeback_buffer (N=4, P=2).
module tb_result_writeback_buffer;

  localparam int unsigned N   = 4;
  localparam int unsigned P   = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned MAB = 64;
  localparam int unsigned SB  = $clog2(4096 + 1);
  localparam int unsigned NB  = N * N / P;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ivalid, iready;
  logic [MAB-1:0]         addr_in;
  logic [SB-1:0]          stride_in;
  logic                   pvalid, pready, plast;
  logic [N-1:0][AW-1:0]   pdata;
  logic                   prev_valid, prev_ready, cur_valid, cur_ready;
  logic                   we, mem_ready, perr;
  logic [MAB-1:0]         maddr;
  logic [P-1:0][AW-1:0]   mdata;

  result_writeback_buffer #(
    .ACC_WIDTH                    (AW),
    .N                            (N),
    .MEMORY_ADDRESS_BITS          (MAB),
    .PARALLEL_DATA_STREAMING_SIZE (P),
    .MAX_MATRIX_LENGTH            (4096),
    .STRIDE_BITS                  (SB)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .i_instruction_valid           (ivalid),
    .o_instruction_ready           (iready),
    .i_address_input               (addr_in),
    .i_stride_input                (stride_in),
    .i_processor_output_valid      (pvalid),
    .o_processor_output_ready      (pready),
    .i_processor_output_data       (pdata),
    .i_processor_output_last       (plast),
    .i_previous_done_writing_valid (prev_valid),
    .o_previous_done_writing_ready (prev_ready),
    .o_current_done_writing_valid  (cur_valid),
    .i_current_done_writing_ready  (cur_ready),
    .o_memory_write_enable         (we),
    .i_memory_write_ready          (mem_ready),
    .o_memory_address              (maddr),
    .o_memory_write_data           (mdata),
    .o_protocol_error              (perr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int done_cnt = 0, tok_cnt = 0, perr_cnt = 0, stall_err = 0;
  logic [MAB-1:0]       obs_addr [$];
  logic [P-1:0][AW-1:0] obs_data [$];
  logic [AW-1:0]        tile [N][N];
  logic [MAB-1:0]       cur_base;
  logic [SB-1:0]        cur_stride;
  logic                 bp_mode = 1'b0;

  // Observers: record accepted beats, tokens, error pulses and stall stability.
  logic                 prev_stall = 1'b0;
  logic [MAB-1:0]       prev_addr;
  logic [P-1:0][AW-1:0] prev_data;
  always @(posedge clk) begin
    if (!reset) begin
      if (we && mem_ready) begin
        obs_addr.push_back(maddr);
        obs_data.push_back(mdata);
      end
      if (prev_stall && (!we || maddr !== prev_addr || mdata !== prev_data))
        stall_err <= stall_err + 1;
      if (cur_valid && cur_ready) done_cnt <= done_cnt + 1;
      if (prev_valid && prev_ready) tok_cnt <= tok_cnt + 1;
      if (perr) perr_cnt <= perr_cnt + 1;
    end
    prev_stall <= !reset && we && !mem_ready;
    prev_addr  <= maddr;
    prev_data  <= mdata;
  end

  // Memory ready: always high, or the 1,0,0,1 pattern under backpressure.
  int bp_ph = 0;
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bp_ph++;
      mem_ready = bp_mode ? ((bp_ph % 4 == 0) || (bp_ph % 4 == 3)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iready"}, 64'(iready), 64'd1);
    check({tag, "_pready"}, 64'(pready), 64'd0);
    check({tag, "_prevrdy"}, 64'(prev_ready), 64'd0);
    check({tag, "_curvld"}, 64'(cur_valid), 64'd0);
    check({tag, "_we"}, 64'(we), 64'd0);
    check({tag, "_addr"}, maddr, 64'd0);
    check({tag, "_data"}, 64'(mdata), 64'd0);
    check({tag, "_perr"}, 64'(perr), 64'd0);
  endtask

  task automatic fill_tile(input bit rnd);
    for (int r = 0; r < int'(N); r++)
      for (int j = 0; j < int'(N); j++)
        tile[r][j] = rnd ? AW'($urandom) : AW'(10 * r + j);
  endtask

  task automatic send_instr(input logic [MAB-1:0] base, input logic [SB-1:0] stride);
    int g = 0;
    cur_base   = base;
    cur_stride = stride;
    obs_addr.delete();
    obs_data.delete();
    ivalid    = 1'b1;
    addr_in   = base;
    stride_in = stride;
    while (!iready && g < 100) begin tick(); g++; end
    check("instr_accept_timeout", 64'(g < 100), 64'd1);
    tick();
    ivalid = 1'b0;
  endtask

  task automatic send_rows(input bit bad_last);
    for (int r = 0; r < int'(N); r++) begin
      int g = 0;
      pvalid = 1'b1;
      for (int j = 0; j < int'(N); j++) pdata[j] = tile[r][j];
      plast = bad_last ? (r == 1) : (r == int'(N) - 1);
      while (!pready && g < 100) begin tick(); g++; end
      check("row_accept_timeout", 64'(g < 100), 64'd1);
      tick();
    end
    pvalid = 1'b0;
    plast  = 1'b0;
  endtask

  // Reference: beat i covers row i/(N/P), columns (i%(N/P))*P .. +P-1.
  task automatic compare_results(input string tag);
    logic [AW-1:0] exp_img [logic [63:0]];
    logic [AW-1:0] got_img [logic [63:0]];
    check({tag, "_beats"}, 64'(obs_addr.size()), 64'(NB));
    for (int i = 0; i < int'(NB) && i < obs_addr.size(); i++) begin
      int r = i / int'(N / P);
      int c = (i % int'(N / P)) * int'(P);
      check({tag, "_addr"}, obs_addr[i], cur_base + 64'(r) * 64'(cur_stride) + 64'(c));
      for (int k = 0; k < int'(P); k++)
        check({tag, "_data"}, 64'(obs_data[i][k]), 64'(tile[r][c + k]));
    end
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        exp_img[cur_base + 64'(r) * 64'(cur_stride) + 64'(c)] = tile[r][c];
    for (int i = 0; i < obs_addr.size(); i++)
      for (int k = 0; k < int'(P); k++)
        got_img[obs_addr[i] + 64'(k)] = obs_data[i][k];
    check({tag, "_img_size"}, 64'(got_img.num()), 64'(exp_img.num()));
    foreach (exp_img[a])
      check({tag, "_img"}, got_img.exists(a) ? 64'(got_img[a]) : {64{1'bx}}, 64'(exp_img[a]));
  endtask

  task automatic finish_tile(input string tag);
    int g = 0;
    int d0 = done_cnt;
    while (!(cur_valid && cur_ready) && g < 300) begin tick(); g++; end
    check({tag, "_done_timeout"}, 64'(g < 300), 64'd1);
    tick();
    check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_iready_after"}, 64'(iready), 64'd1);
    compare_results(tag);
  endtask

  initial begin
    int bad, g, d0, t0, p0;
    ivalid = 0; addr_in = '0; stride_in = '0; pvalid = 0; plast = 0; pdata = '0;
    prev_valid = 1'b1;
    cur_ready  = 1'b1;

    do_reset();
    check_reset_outputs("rst");

    // Basic tile with recognisable data and latency checks.
    fill_tile(0);
    send_instr(64'h1000, SB'(16));
    check("lat_instr_pready", 64'(pready), 64'd1);
    send_rows(0);
    check("lat_write_early", 64'(we), 64'd0);
    tick();
    check("lat_write_first", 64'(we), 64'd1);
    finish_tile("basic");

    // Memory backpressure.
    bp_mode = 1'b1;
    fill_tile(1);
    send_instr(64'($urandom), SB'($urandom_range(0, 4096)));
    send_rows(0);
    finish_tile("bp");
    check("bp_stall_stable", 64'(stall_err), 64'd0);
    bp_mode = 1'b0;

    // Stride 0: last row wins.
    fill_tile(1);
    send_instr(64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)), SB'(0));
    send_rows(0);
    finish_tile("stride0");

    // Misplaced last: tile still ends on the Nth row.
    p0 = perr_cnt;
    fill_tile(1);
    send_instr(64'($urandom), SB'($urandom_range(N, 4096)));
    send_rows(1);
    finish_tile("perr");
    check("perr_pulses", 64'(perr_cnt - p0), 64'd2);

    // Done-token backpressure.
    cur_ready = 1'b0;
    fill_tile(1);
    send_instr(64'($urandom), SB'($urandom_range(0, 4096)));
    send_rows(0);
    g = 0;
    while (!cur_valid && g < 300) begin tick(); g++; end
    check("donebp_timeout", 64'(g < 300), 64'd1);
    bad = 0;
    d0  = done_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!cur_valid || iready) bad++;
    end
    check("donebp_hold", 64'(bad), 64'd0);
    cur_ready = 1'b1;
    tick();
    check("donebp_iready", 64'(iready), 64'd1);
    check("donebp_cnt", 64'(done_cnt - d0), 64'd1);
    compare_results("donebp");

    // Reset during WRITE after two beats.
    fill_tile(1);
    send_instr(64'($urandom), SB'($urandom_range(0, 4096)));
    send_rows(0);
    g = 0;
    while (obs_addr.size() < 2 && g < 100) begin tick(); g++; end
    check("midrst_beats", 64'(obs_addr.size()), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("midrst");
    d0 = done_cnt;
    repeat (5) tick();
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    fill_tile(1);
    send_instr(64'($urandom), SB'($urandom_range(0, 4096)));
    send_rows(0);
    finish_tile("midrst_fresh");

    // Token offered during COLLECT (flag starts empty after reset).
    do_reset();
    prev_valid = 1'b0;
    fill_tile(1);
    send_instr(64'($urandom), SB'($urandom_range(0, 4096)));
    t0 = tok_cnt;
    prev_valid = 1'b1;
    tick();
    prev_valid = 1'b0;
    check("tokc_once", 64'(tok_cnt - t0), 64'd1);
    check("tokc_ready_low", 64'(prev_ready), 64'd0);
    send_rows(0);
    check("tokc_ready_low_wait", 64'(prev_ready), 64'd0);
    check("tokc_we_wait", 64'(we), 64'd0);
    tick();
    check("tokc_we_write", 64'(we), 64'd1);
    finish_tile("tokc");

    // Token withheld for 20 cycles after collection.
    fill_tile(1);
    send_instr(64'($urandom), SB'($urandom_range(0, 4096)));
    send_rows(0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (we) bad++;
    end
    check("tokw_no_write", 64'(bad), 64'd0);
    check("tokw_ready", 64'(prev_ready), 64'd1);
    prev_valid = 1'b1;
    tick();
    prev_valid = 1'b0;
    check("tokw_we_plus1", 64'(we), 64'd0);
    tick();
    check("tokw_we_plus2", 64'(we), 64'd1);
    finish_tile("tokw");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_writeback_buffer.md
Name: result_writeback_buffer

Overview:
- Output-side counterpart of the operand memory buffers in the sum-stationary engine.
- Accepts one N x N result tile from the processor as N row vectors (valid/ready, last) and stores it on chip.
- Waits for its turn on the shared memory port via a done-token chain with neighbouring writeback units.
- Streams the tile to memory PARALLEL_DATA_STREAMING_SIZE values per beat, row-strided.

Parameters:
- ACC_WIDTH, 32, width of one result element (processor output and memory write element).
- N, 4, tile dimension; also vector width from the processor.
- MEMORY_ADDRESS_BITS, 64, memory address width.
- PARALLEL_DATA_STREAMING_SIZE (P), 4, elements per memory write beat; must divide N (elaboration-time check).
- MAX_MATRIX_LENGTH, 4096, maximum row stride in elements.
- STRIDE_BITS, $clog2(MAX_MATRIX_LENGTH+1), width of the stride field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instruction_valid  in  1  instruction offered.
- instruction_ready  out  1  instruction can be accepted.
- address_input  in  MEMORY_ADDRESS_BITS  element address of tile row 0, column 0.
- stride_input  in  STRIDE_BITS  elements between consecutive tile rows in memory.
- processor_output_valid  in  1  result row offered.
- processor_output_ready  out  1  result row can be accepted.
- processor_output_data  in  ACC_WIDTH x [N-1:0]  one result row; index j = column j.
- processor_output_last  in  1  marks the final row of the tile.
- previous_done_writing_valid  in  1  token from the previous unit; tie high on the first unit in the chain.
- previous_done_writing_ready  out  1  token can be accepted.
- current_done_writing_valid  out  1  token to the next unit.
- current_done_writing_ready  in  1  next unit accepts the token.
- memory_write_enable  out  1  write beat valid.
- memory_write_ready  in  1  memory accepts the beat.
- memory_address  out  MEMORY_ADDRESS_BITS  element address of memory_write_data[0].
- memory_write_data  out  ACC_WIDTH x [P-1:0]  elements at memory_address+0 .. memory_address+P-1.
- protocol_error  out  1  one-cycle pulse when last is misplaced.

Behaviour:
- Reset values:
  - State IDLE; all counters 0; token flag 0; address and stride registers 0.
  - instruction_ready = 1; all other outputs 0. The contents of tile storage are don't-care.
- Handshakes: a transfer occurs on a rising edge where valid && ready. Valids do not depend combinationally on readys.
- State machine:
  - IDLE:
    - instruction_ready = 1.
    - On accept: latch address and stride, clear row_cnt, go to COLLECT.
  - COLLECT:
    - processor_output_ready = 1.
    - Each accepted row is stored at row index row_cnt, then row_cnt increments.
    - On the accepted beat with row_cnt == N-1, go to WAIT_TURN.
    - The tile always ends on the Nth beat.
    - last is checked, not obeyed. protocol_error pulses the cycle after an accepted beat where last != (row_cnt == N-1).
  - WAIT_TURN:
    - If the token flag is set, clear it and go to WRITE with row_cnt = 0 and col_cnt = 0.
  - WRITE:
    - memory_write_enable = 1.
    - memory_address = addr_reg + row_cnt*stride_reg + col_cnt, truncated to MEMORY_ADDRESS_BITS.
    - memory_write_data[k] = tile[row_cnt][col_cnt+k].
    - On each accepted beat, col_cnt += P. When col_cnt wraps from N-P to 0, row_cnt increments.
    - On the beat for row N-1, column N-P, go to SIGNAL_DONE.
    - Total beats = N*N/P. A stall (ready low) holds address and data stable.
  - SIGNAL_DONE:
    - current_done_writing_valid = 1 until accepted, then go to IDLE.
    - instruction_ready rises in the cycle after acceptance.
- Token flag:
  - previous_done_writing_ready = ~token_flag && state != IDLE.
  - A token may arrive during COLLECT, so that memory access starts immediately after collection.
  - A token accepted in WAIT_TURN moves the state to WRITE one cycle later, via the flag.
- Latency (all readys held high):
  - Instruction accept to ready for the first row: 1 cycle.
  - Last row accepted to first write beat: 2 cycles if the token is already held.
  - Last write beat to current_done_writing_valid: 1 cycle.
- Stride:
  - Stride 0 is legal; every row writes the same addresses and the last row wins.
  - The row_cnt*stride product uses MEMORY_ADDRESS_BITS width.
- Reset mid-operation: any state returns to IDLE next edge. A held token is discarded, and no done token is emitted.
- Simultaneous events:
  - A token and the final COLLECT beat arriving in the same cycle both take effect; the next state is WAIT_TURN with the flag set.

Decomposition:
- Package writeback_pkg:
  - state enum (IDLE, COLLECT, WAIT_TURN, WRITE, SIGNAL_DONE).
  - Elaboration check helper that P divides N.
- Sub-module result_tile_store: an N x N ACC_WIDTH register array with:
  - row write port (row index, N-wide data, enable);
  - P-wide read port (row, column base).
- The FSM, counters, and address arithmetic live in the top module.

Test Plan:
- Basic tile (N=4, P=4): base 0x1000, stride 16. Feed rows 0..3 with data[j] = 10*r + j, last on row 3, previous token tied high.
  - Required: writes at 0x1000, 0x1010, 0x1020, 0x1030 carrying {0,1,2,3}, {10..13}, {20..23}, {30..33}.
  - Then one done token is issued and instruction_ready returns high.
- Memory backpressure (P=2): memory_write_ready toggles 1,0,0,1,...
  - Required: exactly 8 accepted beats; address and data stable during stalls; same memory image as the unstalled case.
- Token ordering: previous token withheld for 20 cycles after collection.
  - Required: no memory_write_enable until 2 cycles after the token is accepted.
  - Token offered during COLLECT: accepted once; previous_done_writing_ready low afterwards until WRITE.
- Protocol error: last asserted on row 1 and not on row 3.
  - Required: protocol_error pulses twice; the tile is still 4 rows and all 4 rows are written.
- Reset mid-WRITE after 2 beats.
  - Required: next cycle has all outputs at reset values and no done token. A fresh instruction then completes a full tile correctly.
- Done backpressure: current_done_writing_ready held low for 5 cycles.
  - Required: current_done_writing_valid stays high; instruction_ready stays low until the token is accepted.
